bin_to_seg3_seq: RTL and testbench

//  Sequential binary-to-3-digit 7-segment converter. Sits directly downstream of the

---
 rtl/display_pkg.sv | 19 +
 rtl/bin_to_seg3_seq_if.sv | 24 ++
 rtl/seg7_encode.sv | 22 ++
 rtl/bin_to_seg3_seq.sv | 105 ++++++++++
 tb/tb_bin_to_seg3_seq.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared display definitions: conversion FSM states, 7-segment digit table and
// the double-dabble nibble correction used by the binary-to-BCD converter.
package display_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} conv_state_t;

    // Active-high patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [3:0] add3_if_ge5(input logic [3:0] nibble);
        return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
    endfunction

endpackage

// File: rtl/bin_to_seg3_seq_if.sv
// Input handshake plus converted BCD/segment outputs of the binary-to-7-segment
// converter; slave is the converter side, master the producer/consumer side.
interface bin_to_seg3_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_value;
    logic             out_valid;
    logic [11:0]      bcd;
    logic [6:0]       seg_centenas;
    logic [6:0]       seg_decenas;
    logic [6:0]       seg_unidades;

    modport master (
        output in_valid, in_value,
        input  in_ready, out_valid, bcd, seg_centenas, seg_decenas, seg_unidades
    );

    modport slave (
        input  in_valid, in_value,
        output in_ready, out_valid, bcd, seg_centenas, seg_decenas, seg_unidades
    );
endinterface

// File: rtl/seg7_encode.sv
// Combinational BCD digit to 7-segment encoder with blanking and optional
// active-low inversion; non-decimal codes render as blank.
module seg7_encode
    import display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       active_low,
    output logic [6:0] seg
);
    logic [6:0] raw;

    always_comb begin
        raw = SEG_BLANK;
        if (!blank) begin
            for (int i = 0; i < 10; i++) begin
                if (digit == 4'(i)) raw = SEG_DIGIT[i];
            end
        end
        seg = raw ^ {7{active_low}};
    end
endmodule

// File: rtl/bin_to_seg3_seq.sv
// Sequential binary to 3-digit BCD / 7-segment converter using double-dabble,
// one bit per cycle, with outputs that only change on the UPDATE cycle.
module bin_to_seg3_seq
    import display_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int BLANK_LZ       = 0
) (
    input  logic              clk,
    input  logic              reset,
    bin_to_seg3_seq_if.slave  bus
);
    localparam logic       ACTIVE_LOW = (SEG_ACTIVE_LOW != 0);
    localparam logic [6:0] SEG_INV    = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [6:0] SEG_ZERO   = SEG_DIGIT[0] ^ SEG_INV;
    // Leading digits come out of reset blank when leading-zero blanking is on
    localparam logic [6:0] SEG_LEAD   = ((BLANK_LZ != 0) ? SEG_BLANK : SEG_DIGIT[0]) ^ SEG_INV;

    conv_state_t      state_reg, state_next;
    logic [WIDTH-1:0] bin_reg;
    logic [11:0]      acc_reg;
    logic [3:0]       cnt_reg;
    logic [11:0]      bcd_reg;
    logic             out_valid_reg;
    logic [6:0]       seg_reg [3];

    logic [11:0]      acc_adj;
    logic             blank [3];
    logic [6:0]       seg_enc [3];

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.in_valid) state_next = SHIFT;
            SHIFT:   if (cnt_reg == 4'd0) state_next = UPDATE;
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign blank[2] = (BLANK_LZ != 0) && (acc_reg[11:8] == 4'd0);
    assign blank[1] = (BLANK_LZ != 0) && (acc_reg[11:8] == 4'd0) && (acc_reg[7:4] == 4'd0);
    assign blank[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_digit
            assign acc_adj[gi*4 +: 4] = add3_if_ge5(acc_reg[gi*4 +: 4]);

            seg7_encode u_enc (
                .digit      (acc_reg[gi*4 +: 4]),
                .blank      (blank[gi]),
                .active_low (ACTIVE_LOW),
                .seg        (seg_enc[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_reg       <= '0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            bcd_reg       <= '0;
            out_valid_reg <= 1'b0;
            seg_reg[2]    <= SEG_LEAD;
            seg_reg[1]    <= SEG_LEAD;
            seg_reg[0]    <= SEG_ZERO;
        end else begin
            out_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        bin_reg <= bus.in_value;
                        acc_reg <= '0;
                        cnt_reg <= 4'(WIDTH - 1);
                    end
                end
                SHIFT: begin
                    acc_reg <= {acc_adj[10:0], bin_reg[WIDTH-1]};
                    bin_reg <= bin_reg << 1;
                    cnt_reg <= cnt_reg - 4'd1;
                end
                UPDATE: begin
                    bcd_reg       <= acc_reg;
                    out_valid_reg <= 1'b1;
                    for (int i = 0; i < 3; i++) seg_reg[i] <= seg_enc[i];
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready     = (state_reg == IDLE);
    assign bus.out_valid    = out_valid_reg;
    assign bus.bcd          = bcd_reg;
    assign bus.seg_centenas = seg_reg[2];
    assign bus.seg_decenas  = seg_reg[1];
    assign bus.seg_unidades = seg_reg[0];
endmodule

// File: tb/tb_bin_to_seg3_seq.sv
// Directed bench for bin_to_seg3_seq: a default instance and a blanking,
// active-low instance share clock and reset.
module tb_bin_to_seg3_seq;
    logic clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    bin_to_seg3_seq_if #(.WIDTH(8)) bus_a ();
    bin_to_seg3_seq_if #(.WIDTH(8)) bus_b ();

    bin_to_seg3_seq #(.WIDTH(8), .SEG_ACTIVE_LOW(0), .BLANK_LZ(0)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    bin_to_seg3_seq #(.WIDTH(8), .SEG_ACTIVE_LOW(1), .BLANK_LZ(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One conversion on instance A: single-cycle in_valid, checks busy window,
    // result at E9 and hold on the following cycle.
    task automatic convert_a(input logic [7:0] v, input logic [11:0] eb,
                             input logic [6:0] eh, input logic [6:0] et, input logic [6:0] eu);
        @(negedge clk);
        bus_a.in_valid = 1'b1;
        bus_a.in_value = v;
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        chk("ready_low_e0", 32'(bus_a.in_ready), 32'd0);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            if (k < 9) begin
                chk("ready_low_busy", 32'(bus_a.in_ready), 32'd0);
                chk("no_early_valid", 32'(bus_a.out_valid), 32'd0);
            end else begin
                chk("out_valid_e9", 32'(bus_a.out_valid), 32'd1);
                chk("ready_back_e9", 32'(bus_a.in_ready), 32'd1);
                chk("bcd", 32'(bus_a.bcd), 32'(eb));
                chk("seg_h", 32'(bus_a.seg_centenas), 32'(eh));
                chk("seg_t", 32'(bus_a.seg_decenas), 32'(et));
                chk("seg_u", 32'(bus_a.seg_unidades), 32'(eu));
                $display("convert %0d -> bcd %03h segs %02h/%02h/%02h", v,
                         bus_a.bcd, bus_a.seg_centenas, bus_a.seg_decenas, bus_a.seg_unidades);
            end
        end
        @(posedge clk); #1;
        chk("out_valid_pulse", 32'(bus_a.out_valid), 32'd0);
        chk("bcd_hold", 32'(bus_a.bcd), 32'(eb));
    endtask

    initial begin
        int         pulses;
        int         first_k;
        int         second_k;
        logic [11:0] bcd1;
        logic [11:0] bcd2;

        reset = 1'b1;
        bus_a.in_valid = 1'b0;
        bus_a.in_value = '0;
        bus_b.in_valid = 1'b0;
        bus_b.in_value = '0;

        // 1. reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus_a.in_ready), 32'd1);
        chk("rst_bcd", 32'(bus_a.bcd), 32'h000);
        chk("rst_seg_h", 32'(bus_a.seg_centenas), 32'h3F);
        chk("rst_seg_t", 32'(bus_a.seg_decenas), 32'h3F);
        chk("rst_seg_u", 32'(bus_a.seg_unidades), 32'h3F);
        chk("rst_b_seg_h", 32'(bus_b.seg_centenas), 32'h7F);
        chk("rst_b_seg_t", 32'(bus_b.seg_decenas), 32'h7F);
        chk("rst_b_seg_u", 32'(bus_b.seg_unidades), 32'h40);
        $display("reset -> ready %0b valid %0b bcd %03h", bus_a.in_ready, bus_a.out_valid, bus_a.bcd);
        reset = 1'b0;

        // 2./3. single conversions
        convert_a(8'd150, 12'h150, 7'h06, 7'h6D, 7'h3F);
        convert_a(8'd255, 12'h255, 7'h5B, 7'h6D, 7'h6D);
        convert_a(8'd0,   12'h000, 7'h3F, 7'h3F, 7'h3F);
        convert_a(8'd99,  12'h099, 7'h3F, 7'h6F, 7'h6F);

        // 4. back-to-back with in_valid held high
        @(negedge clk);
        bus_a.in_valid = 1'b1;
        bus_a.in_value = 8'd140;
        @(posedge clk); #1;
        bus_a.in_value = 8'd150;
        pulses = 0; first_k = -1; second_k = -1; bcd1 = '0; bcd2 = '0;
        for (int k = 1; k <= 22; k++) begin
            @(posedge clk); #1;
            if (k == 10) bus_a.in_valid = 1'b0;
            if (bus_a.out_valid) begin
                if (pulses == 0) begin first_k = k; bcd1 = bus_a.bcd; end
                else begin second_k = k; bcd2 = bus_a.bcd; end
                pulses++;
            end
        end
        chk("b2b_pulses", 32'(pulses), 32'd2);
        chk("b2b_first_edge", 32'(first_k), 32'd9);
        chk("b2b_second_edge", 32'(second_k), 32'd19);
        chk("b2b_bcd1", 32'(bcd1), 32'h140);
        chk("b2b_bcd2", 32'(bcd2), 32'h150);
        $display("back-to-back -> pulses at E%0d (%03h) and E%0d (%03h)", first_k, bcd1, second_k, bcd2);

        // 5. reset during SHIFT of 130
        @(negedge clk);
        bus_a.in_valid = 1'b1;
        bus_a.in_value = 8'd130;
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_ready", 32'(bus_a.in_ready), 32'd1);
        chk("abort_valid", 32'(bus_a.out_valid), 32'd0);
        chk("abort_bcd", 32'(bus_a.bcd), 32'h000);
        chk("abort_seg_h", 32'(bus_a.seg_centenas), 32'h3F);
        chk("abort_seg_t", 32'(bus_a.seg_decenas), 32'h3F);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (bus_a.out_valid) pulses++;
        end
        chk("abort_no_pulse", 32'(pulses), 32'd0);
        $display("reset mid-shift -> ready %0b bcd %03h pulses %0d", bus_a.in_ready, bus_a.bcd, pulses);

        // 6. blanking, active-low instance
        @(negedge clk);
        bus_b.in_valid = 1'b1;
        bus_b.in_value = 8'd7;
        @(posedge clk); #1;
        bus_b.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("b_out_valid", 32'(bus_b.out_valid), 32'd1);
        chk("b_bcd", 32'(bus_b.bcd), 32'h007);
        chk("b_seg_h", 32'(bus_b.seg_centenas), 32'h7F);
        chk("b_seg_t", 32'(bus_b.seg_decenas), 32'h7F);
        chk("b_seg_u", 32'(bus_b.seg_unidades), 32'h78);
        $display("blank/active-low 7 -> bcd %03h segs %02h/%02h/%02h", bus_b.bcd,
                 bus_b.seg_centenas, bus_b.seg_decenas, bus_b.seg_unidades);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
